// File: rtl/alu_decode_stage_pkg.sv
// Shared cpu definitions for the decode/execute boundary: ALU functions,
// RV32I opcode/funct constants and the decoded execute payload.
package alu_decode_stage_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } alu_function_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        alu_function_t alu_control;
        logic [31:0]   a;
        logic [31:0]   b;
        logic [31:0]   rs2_data;
        logic [4:0]    rd;
        logic          reg_write;
        logic          illegal;
        logic [31:0]   pc;
    } decoded_ex_t;

    function automatic logic [31:0] sext12(input logic [11:0] imm);
        return {{20{imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational RV32I decode into ALU control plus selected operands.
// Encodings the ADD/SUB/AND/OR ALU cannot execute are flagged illegal.
module alu_decoder
    import alu_decode_stage_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output decoded_ex_t dec
);

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_u;
    logic        legal;
    logic        writes_rd;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign imm_i  = sext12(instr[31:20]);
    assign imm_s  = sext12({instr[31:25], instr[11:7]});
    assign imm_u  = {instr[31:12], 12'b0};

    always_comb begin
        dec             = '0;
        dec.alu_control = ALU_ADD;
        dec.rd          = rd;
        dec.rs2_data    = rs2_data;
        dec.pc          = pc;
        legal           = 1'b1;
        writes_rd       = 1'b0;
        unique case (opcode)
            OPC_OP: begin
                dec.a     = rs1_data;
                dec.b     = rs2_data;
                writes_rd = 1'b1;
                // SUB is the only alternate-funct7 form the ALU supports
                if (f3 == F3_ADD_SUB && f7 == F7_ALT) begin
                    dec.alu_control = ALU_SUB;
                end else if (f7 != F7_BASE) begin
                    legal = 1'b0;
                end else begin
                    case (f3)
                        F3_ADD_SUB: dec.alu_control = ALU_ADD;
                        F3_AND:     dec.alu_control = ALU_AND;
                        F3_OR:      dec.alu_control = ALU_OR;
                        default:    legal = 1'b0;
                    endcase
                end
            end
            OPC_OP_IMM: begin
                dec.a     = rs1_data;
                dec.b     = imm_i;
                writes_rd = 1'b1;
                case (f3)
                    F3_ADD_SUB: dec.alu_control = ALU_ADD;
                    F3_AND:     dec.alu_control = ALU_AND;
                    F3_OR:      dec.alu_control = ALU_OR;
                    default:    legal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                dec.a     = rs1_data;
                dec.b     = imm_i;
                writes_rd = 1'b1;
            end
            OPC_STORE: begin
                dec.a = rs1_data;
                dec.b = imm_s;
            end
            OPC_BRANCH: begin
                dec.a           = rs1_data;
                dec.b           = rs2_data;
                dec.alu_control = ALU_SUB;
                legal           = (f3 == F3_BEQ) || (f3 == F3_BNE);
            end
            OPC_LUI: begin
                dec.b     = imm_u;
                writes_rd = 1'b1;
            end
            OPC_AUIPC: begin
                dec.a     = pc;
                dec.b     = imm_u;
                writes_rd = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                dec.a     = pc;
                dec.b     = 32'd4;
                writes_rd = 1'b1;
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            dec.alu_control = ALU_ADD;
            dec.a           = '0;
            dec.b           = '0;
        end
        dec.illegal   = !legal;
        dec.reg_write = writes_rd && legal && (rd != 5'd0);
    end

endmodule

// File: rtl/alu_decode_stage.sv
// ID/EX boundary stage: decodes an instruction and registers the ALU payload
// behind a two-entry (main + skid) buffer so in_ready is a flop.
module alu_decode_stage
    import alu_decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output alu_function_t   out_alu_control,
    output logic [XLEN-1:0] out_a,
    output logic [XLEN-1:0] out_b,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [4:0]      out_rd,
    output logic            out_reg_write,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_pc
);

    // Handshake: a word moves across a port on a rising edge where that
    // port's valid and ready are both high; a held out_valid never drops and
    // its payload never changes until out_ready accepts it.

    decoded_ex_t dec;
    decoded_ex_t main_q;
    decoded_ex_t skid_q;
    logic        main_valid;
    logic        skid_valid;
    logic        in_ready_q;
    logic        in_xfer;
    logic        main_free;

    alu_decoder u_decoder (
        .instr    (in_instr),
        .pc       (in_pc),
        .rs1_data (in_rs1_data),
        .rs2_data (in_rs2_data),
        .dec      (dec)
    );

    assign in_xfer   = in_valid && in_ready_q;
    assign main_free = !main_valid || out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            in_ready_q <= 1'b0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            in_ready_q <= 1'b1;
        end else if (main_free) begin
            // in_ready_q is low whenever skid holds data, so the two
            // refill sources never compete
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else if (in_xfer) begin
                main_q     <= dec;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
            in_ready_q <= 1'b1;
        end else if (in_xfer) begin
            skid_q     <= dec;
            skid_valid <= 1'b1;
            in_ready_q <= 1'b0;
        end else begin
            in_ready_q <= !skid_valid;
        end
    end

    assign in_ready        = in_ready_q;
    assign out_valid       = main_valid;
    assign out_alu_control = main_q.alu_control;
    assign out_a           = main_q.a;
    assign out_b           = main_q.b;
    assign out_rs2_data    = main_q.rs2_data;
    assign out_rd          = main_q.rd;
    assign out_reg_write   = main_q.reg_write;
    assign out_illegal     = main_q.illegal;
    assign out_pc          = main_q.pc;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed bench for alu_decode_stage: decode vectors, skid stall/release,
// flush, async reset and a randomly back-pressured ordering run.
module tb_alu_decode_stage;
    import alu_decode_stage_pkg::*;

    logic          clk;
    logic          reset_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_instr;
    logic [31:0]   in_pc;
    logic [31:0]   in_rs1_data;
    logic [31:0]   in_rs2_data;
    logic          out_valid;
    logic          out_ready;
    alu_function_t out_alu_control;
    logic [31:0]   out_a;
    logic [31:0]   out_b;
    logic [31:0]   out_rs2_data;
    logic [4:0]    out_rd;
    logic          out_reg_write;
    logic          out_illegal;
    logic [31:0]   out_pc;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0]   instr;
        logic [31:0]   rs1;
        logic [31:0]   rs2;
        alu_function_t ctl;
        logic [31:0]   a;
        logic [31:0]   b;
        logic [4:0]    rd;
        logic          wr;
        logic          ill;
    } vec_t;

    vec_t vecs[14];

    alu_decode_stage dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_instr        (in_instr),
        .in_pc           (in_pc),
        .in_rs1_data     (in_rs1_data),
        .in_rs2_data     (in_rs2_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_alu_control (out_alu_control),
        .out_a           (out_a),
        .out_b           (out_b),
        .out_rs2_data    (out_rs2_data),
        .out_rd          (out_rd),
        .out_reg_write   (out_reg_write),
        .out_illegal     (out_illegal),
        .out_pc          (out_pc)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic drive_in(input logic [31:0] instr, input logic [31:0] pc,
                            input logic [31:0] rs1, input logic [31:0] rs2);
        in_valid    = 1'b1;
        in_instr    = instr;
        in_pc       = pc;
        in_rs1_data = rs1;
        in_rs2_data = rs2;
    endtask

    task automatic fill_vectors();
        vecs[0]  = '{32'h403100B3, 32'd10,  32'd3,     ALU_SUB, 32'd10,  32'd3,        5'd1, 1'b1, 1'b0};
        vecs[1]  = '{32'hFFF00293, 32'd0,   32'd0,     ALU_ADD, 32'd0,   32'hFFFFFFFF, 5'd5, 1'b1, 1'b0};
        vecs[2]  = '{32'h123450B7, 32'h55,  32'd0,     ALU_ADD, 32'd0,   32'h12345000, 5'd1, 1'b1, 1'b0};
        vecs[3]  = '{32'h0020A423, 32'h100, 32'hDEAD,  ALU_ADD, 32'h100, 32'd8,        5'd8, 1'b0, 1'b0};
        vecs[4]  = '{32'h003140B3, 32'd7,   32'd9,     ALU_ADD, 32'd0,   32'd0,        5'd1, 1'b0, 1'b1};
        vecs[5]  = '{32'h00316233, 32'hF0,  32'h0F,    ALU_OR,  32'hF0,  32'h0F,       5'd4, 1'b1, 1'b0};
        vecs[6]  = '{32'h0F03F313, 32'hFF,  32'd1,     ALU_AND, 32'hFF,  32'hF0,       5'd6, 1'b1, 1'b0};
        vecs[7]  = '{32'h00001197, 32'd2,   32'd2,     ALU_ADD, 32'h101C, 32'h1000,    5'd3, 1'b1, 1'b0};
        vecs[8]  = '{32'h0000006F, 32'd2,   32'd2,     ALU_ADD, 32'h1020, 32'd4,       5'd0, 1'b0, 1'b0};
        vecs[9]  = '{32'h00208063, 32'd5,   32'd5,     ALU_SUB, 32'd5,   32'd5,        5'd0, 1'b0, 1'b0};
        vecs[10] = '{32'h0020C063, 32'd5,   32'd6,     ALU_ADD, 32'd0,   32'd0,        5'd0, 1'b0, 1'b1};
        vecs[11] = '{32'h023100B3, 32'd4,   32'd4,     ALU_ADD, 32'd0,   32'd0,        5'd1, 1'b0, 1'b1};
        vecs[12] = '{32'hFFC0A283, 32'h100, 32'd0,     ALU_ADD, 32'h100, 32'hFFFFFFFC, 5'd5, 1'b1, 1'b0};
        vecs[13] = '{32'h000100E7, 32'd9,   32'd9,     ALU_ADD, 32'h1034, 32'd4,       5'd1, 1'b1, 1'b0};
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        in_rs1_data = '0;
        in_rs2_data = '0;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_a !== 32'd0 || out_b !== 32'd0 || out_pc !== 32'd0 ||
            out_alu_control !== ALU_ADD || out_reg_write !== 1'b0 || out_illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b a=%h b=%h pc=%h ctl=%0d wr=%b ill=%b, required all zero/ADD",
                     out_valid, out_a, out_b, out_pc, out_alu_control, out_reg_write, out_illegal);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_decode();
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
            drive_in(vecs[i].instr, 32'h1000 + 32'(4 * i), vecs[i].rs1, vecs[i].rs2);
            @(negedge clk);
            in_valid = 1'b0;
            n_checks++;
            if (out_valid !== 1'b1 || out_alu_control !== vecs[i].ctl || out_a !== vecs[i].a ||
                out_b !== vecs[i].b) begin
                n_fail++;
                $display("FAIL decode_ops[%0d] instr=%h: valid=%b ctl=%0d a=%h b=%h, required 1 ctl=%0d a=%h b=%h",
                         i, vecs[i].instr, out_valid, out_alu_control, out_a, out_b,
                         vecs[i].ctl, vecs[i].a, vecs[i].b);
            end
            n_checks++;
            if (out_rd !== vecs[i].rd || out_reg_write !== vecs[i].wr || out_illegal !== vecs[i].ill ||
                out_pc !== 32'h1000 + 32'(4 * i) || out_rs2_data !== vecs[i].rs2) begin
                n_fail++;
                $display("FAIL decode_meta[%0d] instr=%h: rd=%0d wr=%b ill=%b pc=%h rs2=%h, required rd=%0d wr=%b ill=%b pc=%h rs2=%h",
                         i, vecs[i].instr, out_rd, out_reg_write, out_illegal, out_pc, out_rs2_data,
                         vecs[i].rd, vecs[i].wr, vecs[i].ill, 32'h1000 + 32'(4 * i), vecs[i].rs2);
            end
        end
    endtask

    task automatic test_stall_skid();
        @(negedge clk);
        out_ready = 1'b0;
        drive_in(32'h00100093, 32'hA00, 32'd0, 32'd0);
        @(negedge clk);
        drive_in(32'h00200093, 32'hB00, 32'd0, 32'd0);
        @(negedge clk);
        drive_in(32'h00300093, 32'hC00, 32'd0, 32'd0);
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'hA00) begin
            n_fail++;
            $display("FAIL stall_skid_full: in_ready=%b valid=%b pc=%h, required 0/1/a00", in_ready, out_valid, out_pc);
        end
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'hA00 || out_b !== 32'd1) begin
            n_fail++;
            $display("FAIL stall_hold: in_ready=%b valid=%b pc=%h b=%h, required 0/1/a00/1", in_ready, out_valid, out_pc, out_b);
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'hB00 || out_b !== 32'd2 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL release_b: valid=%b pc=%h b=%h in_ready=%b, required 1/b00/2/1", out_valid, out_pc, out_b, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'hC00 || out_b !== 32'd3) begin
            n_fail++;
            $display("FAIL release_c: valid=%b pc=%h b=%h, required 1/c00/3", out_valid, out_pc, out_b);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL release_empty: valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_flush();
        @(negedge clk);
        out_ready = 1'b0;
        drive_in(32'h00100093, 32'hA10, 32'd0, 32'd0);
        @(negedge clk);
        drive_in(32'h00200093, 32'hB10, 32'd0, 32'd0);
        @(negedge clk);
        drive_in(32'h00400093, 32'hD10, 32'd0, 32'd0);
        flush = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_clear: valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_no_d[%0d]: valid=%b pc=%h, required valid 0", i, out_valid, out_pc);
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        out_ready = 1'b0;
        drive_in(32'h00500093, 32'hE00, 32'd0, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'hE00) begin
            n_fail++;
            $display("FAIL pre_reset: valid=%b pc=%h, required 1/e00", out_valid, out_pc);
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_pc !== 32'd0 || out_b !== 32'd0) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b pc=%h b=%h, required 0/0/0", out_valid, out_pc, out_b);
        end
        @(negedge clk);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_recover: in_ready=%b valid=%b, required 1/0", in_ready, out_valid);
        end
    endtask

    // scoreboard-driven run: continuous input, random output back-pressure
    task automatic test_back_to_back(input int cycles, input int ready_pct);
        logic [31:0] next_pc;
        logic [31:0] exp_pc;
        int drain;
        next_pc = 32'h4000;
        exp_q.delete();
        for (int c = 0; c < cycles + 60; c++) begin
            @(negedge clk);
            if (c < cycles) begin
                out_ready = ($urandom_range(99, 0) < ready_pct);
                drive_in(32'h00000013, next_pc, next_pc, 32'd0);
            end else begin
                out_ready = 1'b1;
                in_valid  = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_spurious: got pc=%h, required no output", out_pc);
                end else begin
                    exp_pc = exp_q.pop_front();
                    if (out_pc !== exp_pc || out_a !== exp_pc) begin
                        n_fail++;
                        $display("FAIL b2b_order: pc=%h a=%h, required %h", out_pc, out_a, exp_pc);
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(next_pc);
                next_pc = next_pc + 32'd4;
            end
            if (c >= cycles && exp_q.size() == 0 && !out_valid) break;
        end
        in_valid = 1'b0;
        drain = exp_q.size();
        n_checks++;
        if (drain != 0 || next_pc == 32'h4000) begin
            n_fail++;
            $display("FAIL b2b_drain: %0d left, accepted up to %h, required 0 left and some accepted", drain, next_pc);
        end
    endtask

    initial begin
        fill_vectors();
        test_reset();
        test_decode();
        test_stall_skid();
        test_flush();
        test_async_reset();
        test_back_to_back(40, 100);
        test_back_to_back(200, 50);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
